regfile_wr_arbiter: RTL and testbench

Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: A (ALU result) and B (memory load). Arbitrates with a valid/ready handshake, holds the winner in one registered write slot, and drives the regfile write port from that slot. Exports a pending-write mask for hazard detection. Sits between the execute/memory writeback paths and `regfile`.

---
 rtl/regfile_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types, default widths and the one-hot helper used by the regfile write arbiter.
package regfile_arb_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned R_DEF     = 3;
  localparam int unsigned MAX_R     = 8;
  localparam int unsigned ONEHOT_W  = 2 ** MAX_R;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_t;

  // Callers zero-extend their address to MAX_R bits and truncate the result to 2**R.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [MAX_R-1:0] idx);
    logic [ONEHOT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Pure combinational 2-input arbiter; REGFILE_ARB_RR_EN selects round-robin, otherwise A has fixed priority.
module rr_arb2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  gnt_t       last_gnt_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

`ifdef REGFILE_ARB_RR_EN
  logic [1:0] contend_c;
  // On contention the requester that did not win last time goes next.
  assign contend_c = (last_gnt_i == GNT_A) ? 2'b10 : 2'b01;
`else
  logic [1:0] contend_c;
  logic       unused_last_gnt;
  assign contend_c       = 2'b01;
  assign unused_last_gnt = last_gnt_i;
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = contend_c;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between ALU (A) and load (B) writeback through one registered slot.
// Arbitration policy: round-robin when REGFILE_ARB_RR_EN is defined, fixed A-priority otherwise.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned R = R_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [R-1:0]    a_addr,
  input  logic [N-1:0]    a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [R-1:0]    b_addr,
  input  logic [N-1:0]    b_data,
  input  logic            wr_stall,
  output logic            we3,
  output logic [R-1:0]    wa3,
  output logic [N-1:0]    wd3,
  output logic [2**R-1:0] pend,
  output logic            last_gnt
);

  localparam int unsigned NREG = 2 ** R;

  logic         slot_valid_q, slot_valid_d;
  logic [R-1:0] slot_addr_q, slot_addr_d;
  logic [N-1:0] slot_data_q, slot_data_d;
  gnt_t         last_gnt_q, last_gnt_d;

  logic         slot_free_c;
  logic [1:0]   gnt_c;
  logic         a_acc_c, b_acc_c;

  // Slot can take a new write when empty or draining into the regfile this cycle.
  assign slot_free_c = ~slot_valid_q | ~wr_stall;

  rr_arb2 u_arb (
    .req_i      ({b_valid, a_valid}),
    .last_gnt_i (last_gnt_q),
    .enable_i   (slot_free_c & ~reset),
    .gnt_o      (gnt_c)
  );

  assign a_ready = gnt_c[0];
  assign b_ready = gnt_c[1];
  assign a_acc_c = a_valid & a_ready;
  assign b_acc_c = b_valid & b_ready;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    last_gnt_d   = last_gnt_q;
    if (a_acc_c) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = a_addr;
      slot_data_d  = a_data;
      last_gnt_d   = GNT_A;
    end else if (b_acc_c) begin
      slot_valid_d = 1'b1;
      slot_addr_d  = b_addr;
      slot_data_d  = b_data;
      last_gnt_d   = GNT_B;
    end else if (slot_free_c) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      last_gnt_q   <= GNT_B;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  // Reset is gated in so a slot caught mid-stall never writes while reset is asserted.
  assign we3      = slot_valid_q & ~wr_stall & ~reset;
  assign wa3      = slot_addr_q;
  assign wd3      = slot_data_q;
  assign last_gnt = last_gnt_q;

  always_comb begin
    pend = '0;
    if (!reset) begin
      if (slot_valid_q) pend = pend | NREG'(onehot(MAX_R'(slot_addr_q)));
      if (a_valid)      pend = pend | NREG'(onehot(MAX_R'(a_addr)));
      if (b_valid)      pend = pend | NREG'(onehot(MAX_R'(b_addr)));
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed table-driven bench for regfile_wr_arbiter plus contention and same-address sequences.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid, wr_stall;
  logic        a_ready, b_ready;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        we3;
  logic [2:0]  wa3;
  logic [15:0] wd3;
  logic [7:0]  pend;
  logic        last_gnt;

  int passed = 0;
  int total  = 0;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  regfile_wr_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .wr_stall (wr_stall),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .pend     (pend),
    .last_gnt (last_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference regfile fed by the write port, plus a counter of writes to register 1.
  logic [15:0] rf [8];
  int unsigned wr1_cnt = 0;
  always @(posedge clk) begin
    if (we3) rf[wa3] <= wd3;
    if (we3 && wa3 == 3'd1) wr1_cnt <= wr1_cnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [2:0]  ba;
    logic [15:0] bd;
    logic        st;
    logic        ar;
    logic        br;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [7:0]  pd;
    logic        lg;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic set_in(input logic r, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                        input logic bv, input logic [2:0] ba, input logic [15:0] bd, input logic st);
    reset = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; wr_stall = st;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] prev_addr;
    logic       win_b;
    int unsigned cnt0;

    //            rst av aa  ad       bv ba  bd       st  ar br we wa  wd       pend   lg
    vecs[0]  = '{1, 1, 2, 16'h000F, 1, 4, 16'h000B, 0,  0, 0, 0, 0, 16'h0000, 8'h00, 1};
    vecs[1]  = '{0, 1, 2, 16'h000F, 1, 4, 16'h000B, 0,  1, 0, 0, 0, 16'h0000, 8'h14, 1};
    vecs[2]  = '{0, 0, 2, 16'h000F, 1, 4, 16'h000B, 0,  0, 1, 1, 2, 16'h000F, 8'h14, 0};
    vecs[3]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 1, 4, 16'h000B, 8'h10, 1};
    vecs[4]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 0, 4, 16'h000B, 8'h00, 1};
    vecs[5]  = '{0, 0, 0, 16'h0000, 1, 6, 16'h1234, 0,  0, 1, 0, 4, 16'h000B, 8'h40, 1};
    vecs[6]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 0, 6, 16'h1234, 8'h40, 1};
    vecs[7]  = '{0, 1, 1, 16'h1111, 0, 0, 16'h0000, 1,  0, 0, 0, 6, 16'h1234, 8'h42, 1};
    vecs[8]  = '{0, 1, 1, 16'h1111, 0, 0, 16'h0000, 1,  0, 0, 0, 6, 16'h1234, 8'h42, 1};
    vecs[9]  = '{0, 1, 1, 16'h1111, 0, 0, 16'h0000, 0,  1, 0, 1, 6, 16'h1234, 8'h42, 1};
    vecs[10] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 1, 1, 16'h1111, 8'h02, 0};
    vecs[11] = '{0, 1, 0, 16'hBEEF, 0, 0, 16'h0000, 0,  1, 0, 0, 1, 16'h1111, 8'h01, 0};
    vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 1, 0, 16'hBEEF, 8'h01, 0};
    vecs[13] = '{0, 0, 0, 16'h0000, 1, 5, 16'h5555, 0,  0, 1, 0, 0, 16'hBEEF, 8'h20, 0};
    vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 0, 5, 16'h5555, 8'h20, 1};
    vecs[15] = '{1, 1, 3, 16'h0003, 0, 0, 16'h0000, 1,  0, 0, 0, 5, 16'h5555, 8'h00, 1};
    vecs[16] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 0, 0, 16'h0000, 8'h00, 1};

    set_in(1, 1, 2, 16'h000F, 1, 4, 16'h000B, 0);
    adv();

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad,
             vecs[i].bv, vecs[i].ba, vecs[i].bd, vecs[i].st);
      @(negedge clk);
      check($sformatf("v%0d_a_ready", i),  32'(a_ready),  32'(vecs[i].ar));
      check($sformatf("v%0d_b_ready", i),  32'(b_ready),  32'(vecs[i].br));
      check($sformatf("v%0d_we3", i),      32'(we3),      32'(vecs[i].we));
      check($sformatf("v%0d_wa3", i),      32'(wa3),      32'(vecs[i].wa));
      check($sformatf("v%0d_wd3", i),      32'(wd3),      32'(vecs[i].wd));
      check($sformatf("v%0d_pend", i),     32'(pend),     32'(vecs[i].pd));
      check($sformatf("v%0d_last_gnt", i), 32'(last_gnt), 32'(vecs[i].lg));
      adv();
    end

    // Continuous contention: RR alternates A,B,A,B; fixed priority starves B.
    prev_addr = 3'd0;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 3, 16'h000A, 1, 4, 16'h000B, 0);
      @(negedge clk);
      win_b = RR && (i % 2 == 1);
      check($sformatf("cont%0d_a_ready", i), 32'(a_ready), 32'(!win_b));
      check($sformatf("cont%0d_b_ready", i), 32'(b_ready), 32'(win_b));
      if (i > 0) begin
        check($sformatf("cont%0d_we3", i), 32'(we3), 32'd1);
        check($sformatf("cont%0d_wa3", i), 32'(wa3), 32'(prev_addr));
      end
      prev_addr = win_b ? 3'd4 : 3'd3;
      adv();
    end
    set_in(0, 0, 0, 16'h0000, 1, 4, 16'h000B, 0);
    @(negedge clk);
    check("cont4_b_ready", 32'(b_ready), 32'd1);
    check("cont4_we3",     32'(we3),     32'd1);
    check("cont4_wa3",     32'(wa3),     32'(prev_addr));
    adv();
    set_in(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    @(negedge clk);
    check("cont5_wa3",      32'(wa3),      32'd4);
    check("cont5_wd3",      32'(wd3),      32'h000B);
    check("cont5_last_gnt", 32'(last_gnt), 32'd1);
    adv();

    // Same destination from both requesters: two pulses, the later (B) value lands.
    cnt0 = wr1_cnt;
    set_in(0, 1, 1, 16'h1111, 1, 1, 16'h2222, 0);
    @(negedge clk);
    check("same_a_ready", 32'(a_ready), 32'd1);
    check("same_b_ready", 32'(b_ready), 32'd0);
    check("same_pend",    32'(pend),    32'h02);
    adv();
    set_in(0, 0, 0, 16'h0000, 1, 1, 16'h2222, 0);
    @(negedge clk);
    check("same1_b_ready", 32'(b_ready), 32'd1);
    check("same1_wd3",     32'(wd3),     32'h1111);
    adv();
    set_in(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    @(negedge clk);
    check("same2_we3", 32'(we3), 32'd1);
    check("same2_wd3", 32'(wd3), 32'h2222);
    adv();
    @(negedge clk);
    check("same3_we3",    32'(we3),           32'd0);
    check("same_rf1",     32'(rf[1]),         32'h2222);
    check("same_pulses",  32'(wr1_cnt - cnt0), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
